// File: rtl/uart_tx_fsm.sv
// Buffered 8N1 UART transmitter: byte FIFO on a valid/ready handshake feeding a
// frame FSM that holds the line idle-high for GAP_CLKS before every start bit.
module uart_tx_fsm #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int CLK_PER_BIT = CLK_HZ / BAUD_RATE,
    parameter int GAP_CLKS    = 210_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       sig_out,
    output logic       busy_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0]   BAUD_LAST = 32'(CLK_PER_BIT - 1);
    localparam logic [31:0]   GAP_LAST  = 32'(GAP_CLKS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        GAP   = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   gap_cnt_q, gap_cnt_d;
    logic [31:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          sig_q, sig_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [FIFO_DEPTH-1:0][7:0] mem_q;

    logic fifo_empty;
    logic push;
    logic pop;
    logic baud_last;
    logic gap_last;

    assign fifo_empty = (count_q == '0);
    // Full-count check ignores a same-edge pop, so a full FIFO never accepts.
    assign ready_out  = (count_q < FULL_CNT);
    assign push       = valid_in && ready_out;
    assign baud_last  = (baud_cnt_q == BAUD_LAST);
    assign gap_last   = (gap_cnt_q == GAP_LAST);
    assign pop        = (state_d == START) && (state_q != START);
    assign busy_out   = (state_q != IDLE) || !fifo_empty;
    assign sig_out    = sig_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= GAP;
            gap_cnt_q  <= '0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            sig_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            sig_q      <= sig_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GAP:     if (gap_last) state_d = fifo_empty ? IDLE : START;
            IDLE:    if (!fifo_empty) state_d = START;
            START:   if (baud_last) state_d = DATA;
            DATA:    if (baud_last && bit_idx_q == 3'd7) state_d = STOP;
            STOP:    if (baud_last) state_d = GAP;
            default: state_d = GAP;
        endcase
    end

    // sig_out is registered from the next state so the line tracks each state
    // from the same edge that enters it.
    always_comb begin
        gap_cnt_d  = '0;
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        shift_d    = shift_q;
        sig_d      = 1'b1;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);

        if (state_q == GAP && state_d == GAP) gap_cnt_d = gap_cnt_q + 32'd1;
        if (state_q == START || state_q == DATA || state_q == STOP)
            baud_cnt_d = baud_last ? '0 : baud_cnt_q + 32'd1;
        if (state_q == DATA)
            bit_idx_d = baud_last ? bit_idx_q + 3'd1 : bit_idx_q;

        if (pop)
            shift_d = mem_q[rd_ptr_q];
        else if (state_q == DATA && baud_last)
            shift_d = {1'b0, shift_q[7:1]};

        case (state_d)
            START:   sig_d = 1'b0;
            DATA:    sig_d = shift_d[0];
            default: sig_d = 1'b1;
        endcase
    end
endmodule
